coin_accept: RTL and testbench
==============================

# coin_accept

Front end of the vending machine: accepts one-cycle coin-insert pulses, accumulates credit in cents, and services buy/cancel requests. When a purchase is covered, or the user cancels, it hands `money`/`price` to `coin_return` with a one-cycle `start` pulse. It then holds those values stable until `coin_return` raises `done`, clears its credit and resumes collecting. It is the upstream initiator feeding `coin_return`.

## Interface
Parameters:
- `CREDIT_CAP`, default 500: maximum credit in cents; must be ≤ 511.
- `DONE_TIMEOUT`, default 2000: cycles to wait for `done` before faulting.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `coin_B`, `coin_Q`, `coin_D`, `coin_N`, `coin_P`  in  1 each  coin-insert pulses worth 100, 25, 10, 5 and 1 cents.
- `buy`  in  1  purchase request pulse.
- `price_in`  in  9  item price in cents, sampled when `buy` is high.
- `cancel`  in  1  refund request pulse.
- `done`  in  1  from `coin_return`: dispensing finished.
- `money`  out  9  credit in cents; to `coin_return.money`.
- `price`  out  9  latched price, or 0 on cancel; to `coin_return.price`.
- `start`  out  1  one-cycle launch pulse to `coin_return`.
- `vend`  out  1  one-cycle pulse meaning the item is released.
- `reject`  out  1  one-cycle pulse meaning a coin was returned and not credited.
- `short`  out  1  one-cycle pulse meaning the buy was refused for insufficient credit.
- `busy`  out  1  high in LAUNCH and WAIT.
- `err`  out  1  sticky `done` timeout flag.

## Operation
- States: COLLECT, LAUNCH, WAIT.
- Reset value of every output is 0; state after reset is COLLECT. Reset is honoured mid-transaction: credit is lost and any `start` in flight is dropped.
- COLLECT, evaluated in priority order each cycle:
  - `cancel`: latch `price`=0, go to LAUNCH, no `vend`.
  - else `buy`:
    - If `money` ≥ `price_in`: latch `price`=`price_in`, go to LAUNCH, assert `vend`.
    - Otherwise pulse `short` next cycle and stay in COLLECT.
  - else coins:
    - Exactly one coin pulse high, and `money`+value ≤ `CREDIT_CAP`: add the value to `money`.
    - Coin that would exceed the cap: `reject` pulse, credit unchanged.
    - More than one coin pulse high: credit the highest-value coin under the cap rule; `reject` pulse for the rest.
  - A coin arriving in the same cycle as `buy` or `cancel` is rejected.
- LAUNCH: `start`=1 for exactly this one cycle, then go to WAIT.
- WAIT:
  - All coins are rejected; `buy` and `cancel` are ignored.
  - On `done`=1: `money`←0, `price`←0, go to COLLECT.
  - A watchdog counts cycles spent in WAIT. On reaching `DONE_TIMEOUT`: set `err`, clear `money` and `price`, go to COLLECT.
- Width rules:
  - The sum is computed at 10 bits and compared against `CREDIT_CAP`, so no wrap is possible.
  - The change passed downstream is `money`−`price`, never negative; this is guaranteed by the buy check.
- Buy at `price_in`=0 is always accepted: a full refund plus `vend`.

## Timing
- All outputs are registered.
- Coin pulse in cycle n: `money` updated in cycle n+1.
- `buy` or `cancel` accepted in cycle n: state is LAUNCH in cycle n+1, with `start`=1, `busy`=1, `vend`=1 on buy, and `price` valid.
- Cycle n+2: WAIT; `start`=0.
- `money` and `price` are stable from the LAUNCH cycle until the cycle after `done` is sampled.
- `done` sampled high in cycle m during WAIT: COLLECT in m+1, with `money`=0 and `busy`=0. A coin arriving in m+1 is credited normally.
- `done` high while in COLLECT or LAUNCH is ignored.
- `short` and `reject` fire in the cycle after the offending input.
- Back-to-back purchases are possible with a minimum period of 3 cycles plus the `coin_return` latency.

## Test plan
- Reset, then Q, Q, D, N, P on separate cycles → `money`=66 one cycle after the last coin; no `reject`.
- Credit 285, then `buy` with `price_in`=100 → next cycle `start`=1, `vend`=1, `money`=285, `price`=100. Outputs hold until `done`, then `money`=0. With `coin_return` attached: 185 cents returned as 1 B, 3 Q, 1 D.
- Credit 90, `buy` with `price_in`=100 → `short` pulse, no `start`, `money` stays 90. Then insert D and buy again → accepted.
- Credit 450:
  - Insert B → `reject`, `money` stays 450.
  - Assert `coin_Q` and `coin_D` together → `money`=475, `reject` pulses once.
- Credit 37, then `cancel` → `start` with `price`=0, no `vend`. In WAIT, insert N → `reject`. After `done`: COLLECT with `money`=0.
- Reach WAIT and never assert `done` → after 2000 cycles `err`=1 (sticky) and state COLLECT. Then assert `reset` asynchronously mid-WAIT in a fresh run → all outputs 0 immediately.

Source files
------------

// File: rtl/coin_accept.sv
// Coin acceptor front end: credits coin pulses up to a cap, services buy/cancel,
// and launches coin_return with stable money/price until it reports done.
module coin_accept #(
    parameter int CREDIT_CAP   = 500,
    parameter int DONE_TIMEOUT = 2000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       coin_B,
    input  logic       coin_Q,
    input  logic       coin_D,
    input  logic       coin_N,
    input  logic       coin_P,
    input  logic       buy,
    input  logic [8:0] price_in,
    input  logic       cancel,
    input  logic       done,
    output logic [8:0] money,
    output logic [8:0] price,
    output logic       start,
    output logic       vend,
    output logic       reject,
    output logic       short,
    output logic       busy,
    output logic       err
);

    localparam int            WD_W    = $clog2(DONE_TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(DONE_TIMEOUT - 1);
    localparam logic [9:0]    CAP10   = 10'(CREDIT_CAP);

    typedef enum logic [1:0] {
        S_COLLECT,
        S_LAUNCH,
        S_WAIT
    } state_t;

    state_t          state_q, state_d;
    logic [8:0]      money_q, money_d;
    logic [8:0]      price_q, price_d;
    logic            start_q, start_d;
    logic            vend_q, vend_d;
    logic            reject_q, reject_d;
    logic            short_q, short_d;
    logic            busy_q, busy_d;
    logic            err_q, err_d;
    logic [WD_W-1:0] wdog_q, wdog_d;

    logic [2:0] coin_cnt;
    logic [9:0] coin_val;
    logic [9:0] sum;
    logic       any_coin;

    always_comb begin
        coin_cnt = {2'b00, coin_B} + {2'b00, coin_Q} + {2'b00, coin_D}
                 + {2'b00, coin_N} + {2'b00, coin_P};
        any_coin = (coin_cnt != 3'd0);
        // Only the most valuable coin of a simultaneous group is a credit candidate.
        if (coin_B)      coin_val = 10'd100;
        else if (coin_Q) coin_val = 10'd25;
        else if (coin_D) coin_val = 10'd10;
        else if (coin_N) coin_val = 10'd5;
        else if (coin_P) coin_val = 10'd1;
        else             coin_val = 10'd0;
        sum = {1'b0, money_q} + coin_val;
    end

    always_comb begin
        state_d  = state_q;
        money_d  = money_q;
        price_d  = price_q;
        start_d  = 1'b0;
        vend_d   = 1'b0;
        reject_d = 1'b0;
        short_d  = 1'b0;
        err_d    = err_q;
        wdog_d   = wdog_q;

        case (state_q)
            S_COLLECT: begin
                if (cancel) begin
                    price_d  = 9'd0;
                    state_d  = S_LAUNCH;
                    start_d  = 1'b1;
                    reject_d = any_coin;
                end else if (buy) begin
                    reject_d = any_coin;
                    if (money_q >= price_in) begin
                        price_d = price_in;
                        state_d = S_LAUNCH;
                        start_d = 1'b1;
                        vend_d  = 1'b1;
                    end else begin
                        short_d = 1'b1;
                    end
                end else if (any_coin) begin
                    if (sum <= CAP10) money_d = sum[8:0];
                    else              reject_d = 1'b1;
                    if (coin_cnt > 3'd1) reject_d = 1'b1;
                end
            end
            S_LAUNCH: begin
                state_d  = S_WAIT;
                wdog_d   = '0;
                reject_d = any_coin;
            end
            S_WAIT: begin
                reject_d = any_coin;
                if (done) begin
                    money_d = 9'd0;
                    price_d = 9'd0;
                    state_d = S_COLLECT;
                end else if (wdog_q == WD_LAST) begin
                    // coin_return never answered: abandon the transaction and flag it.
                    err_d   = 1'b1;
                    money_d = 9'd0;
                    price_d = 9'd0;
                    state_d = S_COLLECT;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            default: state_d = S_COLLECT;
        endcase

        busy_d = (state_d != S_COLLECT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_COLLECT;
            money_q  <= 9'd0;
            price_q  <= 9'd0;
            start_q  <= 1'b0;
            vend_q   <= 1'b0;
            reject_q <= 1'b0;
            short_q  <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            wdog_q   <= '0;
        end else begin
            state_q  <= state_d;
            money_q  <= money_d;
            price_q  <= price_d;
            start_q  <= start_d;
            vend_q   <= vend_d;
            reject_q <= reject_d;
            short_q  <= short_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            wdog_q   <= wdog_d;
        end
    end

    assign money  = money_q;
    assign price  = price_q;
    assign start  = start_q;
    assign vend   = vend_q;
    assign reject = reject_q;
    assign short  = short_q;
    assign busy   = busy_q;
    assign err    = err_q;

endmodule

// File: tb/tb_coin_accept.sv
// Bench for coin_accept: vector table, hand-written multi-cycle sequences,
// and a randomized run against a transaction-level model of the acceptor.
module tb_coin_accept;

    logic       clk;
    logic       reset;
    logic       coin_B, coin_Q, coin_D, coin_N, coin_P;
    logic       buy;
    logic [8:0] price_in;
    logic       cancel;
    logic       done;
    logic [8:0] money, price;
    logic       start, vend, reject, short, busy, err;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [4:0] C0 = 5'b00000;
    localparam logic [4:0] CB = 5'b10000;
    localparam logic [4:0] CQ = 5'b01000;
    localparam logic [4:0] CD = 5'b00100;
    localparam logic [4:0] CN = 5'b00010;
    localparam logic [4:0] CP = 5'b00001;

    typedef struct {
        logic [4:0]  coins;
        logic        b;
        logic [8:0]  p;
        logic        cn;
        logic        d;
        logic [24:0] exp;
    } vec_t;

    vec_t tq[$];

    coin_accept dut (
        .clk(clk), .reset(reset),
        .coin_B(coin_B), .coin_Q(coin_Q), .coin_D(coin_D), .coin_N(coin_N), .coin_P(coin_P),
        .buy(buy), .price_in(price_in), .cancel(cancel), .done(done),
        .money(money), .price(price), .start(start), .vend(vend),
        .reject(reject), .short(short), .busy(busy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL time_limit: simulation still running, required to finish");
        $fatal(1, "time limit");
    end

    function automatic logic [24:0] pack(input int m, input int pr, input logic st, input logic v,
                                         input logic rj, input logic sh, input logic bz, input logic e);
        return {9'(m), 9'(pr), st, v, rj, sh, bz, e};
    endfunction

    function automatic logic [24:0] outs();
        return {money, price, start, vend, reject, short, busy, err};
    endfunction

    function automatic vec_t mk(input logic [4:0] c, input logic b, input int p, input logic cn,
                                input logic d, input int m, input int pr, input logic st,
                                input logic v, input logic rj, input logic sh, input logic bz);
        vec_t r;
        r.coins = c; r.b = b; r.p = 9'(p); r.cn = cn; r.d = d;
        r.exp = pack(m, pr, st, v, rj, sh, bz, 1'b0);
        return r;
    endfunction

    task automatic drive(input logic [4:0] c, input logic b, input logic [8:0] p,
                         input logic cn, input logic d);
        {coin_B, coin_Q, coin_D, coin_N, coin_P} = c;
        buy = b; price_in = p; cancel = cn; done = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [24:0] act, input logic [24:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got m=%0d p=%0d flags=%b, expected m=%0d p=%0d flags=%b",
                     nm, act[24:16], act[15:7], act[6:0], req[24:16], req[15:7], req[6:0]);
        end
    endtask

    // Reference model: acceptor described as credit/price plus a transaction phase.
    int m_money, m_price, m_phase, m_wd;
    bit m_err;

    function automatic int best_coin(input logic [4:0] c);
        if (c[4]) return 100;
        if (c[3]) return 25;
        if (c[2]) return 10;
        if (c[1]) return 5;
        if (c[0]) return 1;
        return 0;
    endfunction

    function automatic logic [24:0] model_step(input logic [4:0] c, input logic b, input int p,
                                               input logic cn, input logic d);
        logic st = 0, v = 0, rj = 0, sh = 0;
        int n = $countones(c);
        if (m_phase == 0) begin
            if (cn || b) rj = (n > 0);
            if (cn) begin
                m_price = 0; m_phase = 1; st = 1;
            end else if (b) begin
                if (m_money >= p) begin m_price = p; m_phase = 1; st = 1; v = 1; end
                else sh = 1;
            end else if (n > 0) begin
                if (m_money + best_coin(c) <= 500) m_money += best_coin(c);
                else rj = 1;
                if (n > 1) rj = 1;
            end
        end else if (m_phase == 1) begin
            rj = (n > 0); m_phase = 2; m_wd = 0;
        end else begin
            rj = (n > 0);
            m_wd++;
            if (d || m_wd >= 2000) begin
                if (!d) m_err = 1;
                m_money = 0; m_price = 0; m_phase = 0;
            end
        end
        return pack(m_money, m_price, st, v, rj, sh, m_phase != 0, m_err);
    endfunction

    initial begin
        reset = 1'b1;
        {coin_B, coin_Q, coin_D, coin_N, coin_P} = C0;
        buy = 0; price_in = 0; cancel = 0; done = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", outs(), 25'd0);
        #2 reset = 1'b0;
        @(posedge clk); #1;
        chk("after_reset_idle", outs(), 25'd0);

        //            coins  b  p    cn d   money pr  st v rj sh bz
        tq.push_back(mk(CQ,    0, 0,   0, 0,  25,   0,  0, 0, 0, 0, 0));
        tq.push_back(mk(CQ,    0, 0,   0, 0,  50,   0,  0, 0, 0, 0, 0));
        tq.push_back(mk(CD,    0, 0,   0, 0,  60,   0,  0, 0, 0, 0, 0));
        tq.push_back(mk(CN,    0, 0,   0, 0,  65,   0,  0, 0, 0, 0, 0));
        tq.push_back(mk(CP,    0, 0,   0, 0,  66,   0,  0, 0, 0, 0, 0));
        tq.push_back(mk(C0,    1, 100, 0, 0,  66,   0,  0, 0, 0, 1, 0));
        tq.push_back(mk(CB,    0, 0,   0, 0,  166,  0,  0, 0, 0, 0, 0));
        tq.push_back(mk(C0,    1, 100, 0, 1,  166,  100,1, 1, 0, 0, 1));
        tq.push_back(mk(C0,    0, 0,   0, 1,  166,  100,0, 0, 0, 0, 1));
        tq.push_back(mk(CN,    0, 0,   0, 0,  166,  100,0, 0, 1, 0, 1));
        tq.push_back(mk(C0,    1, 10,  1, 0,  166,  100,0, 0, 0, 0, 1));
        tq.push_back(mk(C0,    0, 0,   0, 1,  0,    0,  0, 0, 0, 0, 0));
        tq.push_back(mk(CB,    0, 0,   0, 0,  100,  0,  0, 0, 0, 0, 0));
        tq.push_back(mk(CB,    0, 0,   0, 0,  200,  0,  0, 0, 0, 0, 0));
        tq.push_back(mk(CB,    0, 0,   0, 0,  300,  0,  0, 0, 0, 0, 0));
        tq.push_back(mk(CB,    0, 0,   0, 0,  400,  0,  0, 0, 0, 0, 0));
        tq.push_back(mk(CQ,    0, 0,   0, 0,  425,  0,  0, 0, 0, 0, 0));
        tq.push_back(mk(CQ,    0, 0,   0, 0,  450,  0,  0, 0, 0, 0, 0));
        tq.push_back(mk(CB,    0, 0,   0, 0,  450,  0,  0, 0, 1, 0, 0));
        tq.push_back(mk(CQ|CD, 0, 0,   0, 0,  475,  0,  0, 0, 1, 0, 0));
        tq.push_back(mk(CQ,    0, 0,   0, 0,  500,  0,  0, 0, 0, 0, 0));
        tq.push_back(mk(CP,    0, 0,   0, 0,  500,  0,  0, 0, 1, 0, 0));
        tq.push_back(mk(CP,    0, 0,   1, 0,  500,  0,  1, 0, 1, 0, 1));
        tq.push_back(mk(C0,    0, 0,   0, 0,  500,  0,  0, 0, 0, 0, 1));
        tq.push_back(mk(C0,    0, 0,   0, 1,  0,    0,  0, 0, 0, 0, 0));
        tq.push_back(mk(C0,    1, 0,   0, 0,  0,    0,  1, 1, 0, 0, 1));
        tq.push_back(mk(C0,    0, 0,   0, 1,  0,    0,  0, 0, 0, 0, 1));
        tq.push_back(mk(C0,    0, 0,   0, 1,  0,    0,  0, 0, 0, 0, 0));
        tq.push_back(mk(C0,    1, 5,   1, 0,  0,    0,  1, 0, 0, 0, 1));
        tq.push_back(mk(C0,    0, 0,   0, 0,  0,    0,  0, 0, 0, 0, 1));
        tq.push_back(mk(C0,    0, 0,   0, 1,  0,    0,  0, 0, 0, 0, 0));
        tq.push_back(mk(CQ,    0, 0,   0, 0,  25,   0,  0, 0, 0, 0, 0));
        tq.push_back(mk(CQ,    0, 0,   0, 0,  50,   0,  0, 0, 0, 0, 0));
        tq.push_back(mk(CQ,    0, 0,   0, 0,  75,   0,  0, 0, 0, 0, 0));
        tq.push_back(mk(CD,    0, 0,   0, 0,  85,   0,  0, 0, 0, 0, 0));
        tq.push_back(mk(CN,    0, 0,   0, 0,  90,   0,  0, 0, 0, 0, 0));
        tq.push_back(mk(C0,    1, 100, 0, 0,  90,   0,  0, 0, 0, 1, 0));
        tq.push_back(mk(CD,    0, 0,   0, 0,  100,  0,  0, 0, 0, 0, 0));
        tq.push_back(mk(C0,    1, 100, 0, 0,  100,  100,1, 1, 0, 0, 1));
        tq.push_back(mk(C0,    0, 0,   0, 0,  100,  100,0, 0, 0, 0, 1));
        tq.push_back(mk(C0,    0, 0,   0, 1,  0,    0,  0, 0, 0, 0, 0));

        for (int i = 0; i < tq.size(); i++) begin
            drive(tq[i].coins, tq[i].b, tq[i].p, tq[i].cn, tq[i].d);
            chk($sformatf("row%0d", i), outs(), tq[i].exp);
        end

        // 285 credit, buy at 100: values held through WAIT until done.
        drive(CB, 0, 0, 0, 0); drive(CB, 0, 0, 0, 0);
        drive(CQ, 0, 0, 0, 0); drive(CQ, 0, 0, 0, 0); drive(CQ, 0, 0, 0, 0);
        drive(CD, 0, 0, 0, 0);
        chk("credit_285", outs(), pack(285, 0, 0, 0, 0, 0, 0, 0));
        drive(C0, 1, 100, 0, 0);
        chk("buy_285_launch", outs(), pack(285, 100, 1, 1, 0, 0, 1, 0));
        for (int i = 0; i < 4; i++) begin
            drive(C0, 0, 0, 0, 0);
            chk($sformatf("hold_%0d", i), outs(), pack(285, 100, 0, 0, 0, 0, 1, 0));
        end
        drive(C0, 0, 0, 0, 1);
        chk("done_clears", outs(), pack(0, 0, 0, 0, 0, 0, 0, 0));

        // Watchdog: enter WAIT and never answer.
        drive(CB, 0, 0, 0, 0);
        drive(C0, 1, 50, 0, 0);
        chk("wd_launch", outs(), pack(100, 50, 1, 1, 0, 0, 1, 0));
        for (int j = 1; j <= 2000; j++) begin
            drive(C0, 0, 0, 0, 0);
            if (j == 2000) chk("wd_last_wait", outs(), pack(100, 50, 0, 0, 0, 0, 1, 0));
        end
        drive(C0, 0, 0, 0, 0);
        chk("wd_timeout", outs(), pack(0, 0, 0, 0, 0, 0, 0, 1));
        drive(CQ, 0, 0, 0, 0);
        chk("err_sticky", outs(), pack(25, 0, 0, 0, 0, 0, 0, 1));

        // Asynchronous reset in the middle of WAIT.
        drive(C0, 1, 20, 0, 0);
        drive(C0, 0, 0, 0, 0);
        chk("pre_async_reset", outs(), pack(25, 20, 0, 0, 0, 0, 1, 1));
        #3 reset = 1'b1;
        #1;
        chk("async_reset", outs(), 25'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        drive(CD, 0, 0, 0, 0);
        chk("post_reset_coin", outs(), pack(10, 0, 0, 0, 0, 0, 0, 0));

        // Randomized run against the model.
        m_money = 10; m_price = 0; m_phase = 0; m_wd = 0; m_err = 0;
        for (int k = 0; k < 3000; k++) begin
            logic [4:0]  c;
            logic        b, cn, d;
            int          p;
            logic [24:0] e;
            for (int q = 0; q < 5; q++) c[q] = ($urandom_range(0, 5) == 0);
            b  = ($urandom_range(0, 9) == 0);
            cn = ($urandom_range(0, 29) == 0);
            d  = ($urandom_range(0, 3) == 0);
            p  = $urandom_range(0, 511);
            e  = model_step(c, b, p, cn, d);
            drive(c, b, 9'(p), cn, d);
            chk($sformatf("rand%0d", k), outs(), e);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
